// File: rtl/gf_pkg.sv
// Shared guided-filter definitions: frame geometry, bus widths, coefficient
// fixed-point format and the frame-handshake state encoding.
package gf_pkg;

  localparam int IMG_W  = 400;
  localparam int IMG_H  = 300;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 24;
  localparam int FRAC   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gf_state_e;

endpackage

// File: rtl/gf_delay_line.sv
// DEPTH x WIDTH shift register with synchronous active-low reset. The top bit
// of every stage is exported so a caller can use it as a per-stage valid flag.
module gf_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [DEPTH-1:0] flags
);

  // Stage 0 sits in the low slice; the oldest entry is at the top.
  logic [DEPTH*WIDTH-1:0] stages_q;
  logic [DEPTH*WIDTH-1:0] stages_d;

  if (DEPTH == 1) begin : g_one
    always_comb stages_d = din;
  end else begin : g_many
    always_comb stages_d = {stages_q[(DEPTH-1)*WIDTH-1:0], din};
  end

  // NOTE: every stage is reset, not just the valid bits, because the chain is
  // a handful of flops and a clean reset keeps wrAddr free of stale X values.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) stages_q <= '0;
    else         stages_q <= stages_d;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) flags[i] = stages_q[i*WIDTH + WIDTH-1];
  end

  assign dout = stages_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/calcu_q.sv
// Final guided-filter stage: q = sat(((a*I) >> FRAC) + b) per pixel, streamed
// from the I/a/b frame RAMs to the output RAM. Define CALCU_Q_ROUND_EN to round half-up.
module calcu_q #(
  parameter int IMG_W  = gf_pkg::IMG_W,
  parameter int IMG_H  = gf_pkg::IMG_H,
  parameter int FRAC   = gf_pkg::FRAC,
  parameter int RD_LAT = 1,
  parameter int QMAX   = 255
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  input  logic                      ena,
  output logic                      done,
  output logic [gf_pkg::ADDR_W-1:0] rdAddr,
  input  logic [gf_pkg::DATA_W-1:0] oDataI,
  input  logic [gf_pkg::DATA_W-1:0] oDataA,
  input  logic [gf_pkg::DATA_W-1:0] oDataB,
  output logic                      wren,
  output logic [gf_pkg::ADDR_W-1:0] wrAddr,
  output logic [gf_pkg::DATA_W-1:0] iDataQ
);

  import gf_pkg::ADDR_W;
  import gf_pkg::DATA_W;
  import gf_pkg::gf_state_e;
  import gf_pkg::IDLE;
  import gf_pkg::RUN;
  import gf_pkg::DRAIN;
  import gf_pkg::DONE;

  localparam int                NPIX      = IMG_W * IMG_H;
  localparam int                CHAIN_W   = 1 + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [48:0]       QMAX_W    = 49'(QMAX);

  gf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] q_q, q_d;

  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic [RD_LAT-1:0] pipe_flags;
  logic              pipe_busy;

  // Each issued address rides alongside its valid bit until the RAM data for
  // that address is on oDataI/oDataA/oDataB.
  gf_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (CHAIN_W)
  ) u_addr_chain (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .din    ({state_q == RUN, rd_addr_q}),
    .dout   ({pipe_valid, pipe_addr}),
    .flags  (pipe_flags)
  );

  assign pipe_busy = |pipe_flags;

  logic [47:0] prod;
  logic [47:0] sh;
  logic [48:0] sum;
  logic [DATA_W-1:0] q_calc;

  always_comb begin
    prod = {24'd0, oDataA} * {24'd0, oDataI};
`ifdef CALCU_Q_ROUND_EN
    sh = (prod + (48'd1 << (FRAC - 1))) >> FRAC;
`else
    sh = prod >> FRAC;
`endif
    sum    = {1'b0, sh} + {25'd0, oDataB};
    q_calc = (sum > QMAX_W) ? DATA_W'(QMAX) : sum[DATA_W-1:0];
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena) begin
          state_d   = RUN;
          rd_addr_d = '0;
        end
      end
      RUN: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d   = DRAIN;
          rd_addr_d = '0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // Chain empty means the final write is in the output register now,
        // so done lands exactly one cycle after it.
        if (!pipe_busy) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wren_d    = pipe_valid;
    wr_addr_d = pipe_valid ? pipe_addr : wr_addr_q;
    q_d       = pipe_valid ? q_calc    : q_q;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      wren_q    <= 1'b0;
      wr_addr_q <= '0;
      q_q       <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      done_q    <= done_d;
      wren_q    <= wren_d;
      wr_addr_q <= wr_addr_d;
      q_q       <= q_d;
    end
  end

  assign rdAddr = rd_addr_q;
  assign done   = done_q;
  assign wren   = wren_q;
  assign wrAddr = wr_addr_q;
  assign iDataQ = q_q;

endmodule

// File: tb/tb_calcu_q.sv
// Directed bench for calcu_q on a 4x2 frame: dut_a (RD_LAT=1, constant RAM
// data) and dut_b (RD_LAT=3, address-dependent guide data).
module tb_calcu_q;

  localparam int NPIX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, ena_a, ena_b;
  logic        done_a, done_b, wren_a, wren_b;
  logic [16:0] rd_a, rd_b, wa_a, wa_b;
  logic [23:0] q_a, q_b;
  logic [23:0] di_a, da_a, db_a, di_b, da_b, db_b;
  logic [23:0] a_cfg, i_cfg, b_cfg;

  calcu_q #(.IMG_W(4), .IMG_H(2), .RD_LAT(1)) dut_a (
    .iCLK(clk), .iRST_N(rst_a), .ena(ena_a), .done(done_a), .rdAddr(rd_a),
    .oDataI(di_a), .oDataA(da_a), .oDataB(db_a),
    .wren(wren_a), .wrAddr(wa_a), .iDataQ(q_a)
  );

  calcu_q #(.IMG_W(4), .IMG_H(2), .RD_LAT(3)) dut_b (
    .iCLK(clk), .iRST_N(rst_b), .ena(ena_b), .done(done_b), .rdAddr(rd_b),
    .oDataI(di_b), .oDataA(da_b), .oDataB(db_b),
    .wren(wren_b), .wrAddr(wa_b), .iDataQ(q_b)
  );

  // One-cycle RAM returning the configured constants.
  always @(posedge clk) begin
    da_a <= a_cfg;
    di_a <= i_cfg;
    db_a <= b_cfg;
  end

  // Three-cycle RAM with I = address, a = 1.0, b = 0, so q must equal wrAddr.
  logic [16:0] pb0, pb1, pb2;
  always @(posedge clk) begin
    pb0 <= rd_b;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign di_b = {7'd0, pb2};
  assign da_b = 24'd128;
  assign db_b = 24'd0;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ena(input int which, input logic v);
    if (which != 0) ena_b = v;
    else            ena_a = v;
  endtask

  // kk counts falling edges after the edge that sampled ena (kk=1 is the
  // cycle of the first read).
  task automatic cycle_check(input int which, input int kk, input logic [23:0] exp_q,
                             input bit q_is_addr, input string tag);
    int          lat, first;
    logic        w, d;
    logic [16:0] ra, wa;
    logic [23:0] q;
    bit          exp_w;
    if (which != 0) begin
      lat = 3; w = wren_b; d = done_b; ra = rd_b; wa = wa_b; q = q_b;
    end else begin
      lat = 1; w = wren_a; d = done_a; ra = rd_a; wa = wa_a; q = q_a;
    end
    first = lat + 2;
    exp_w = (kk >= first) && (kk < first + NPIX);
    check({tag, " wren"}, 32'(w), 32'(exp_w));
    if (exp_w && w) begin
      check({tag, " wrAddr"}, 32'(wa), 32'(kk - first));
      check({tag, " q"}, 32'(q), q_is_addr ? 32'(kk - first) : 32'(exp_q));
    end
    check({tag, " done"}, 32'(d), 32'(kk == first + NPIX));
    check({tag, " rdAddr"}, 32'(ra), (kk <= NPIX) ? 32'(kk - 1) : 32'd0);
  endtask

  task automatic run_frame(input int which, input logic [23:0] exp_q,
                           input bit q_is_addr, input string tag);
    int lat;
    lat = (which != 0) ? 3 : 1;
    @(negedge clk);
    set_ena(which, 1'b1);
    for (int kk = 1; kk <= NPIX + lat + 4; kk++) begin
      @(negedge clk);
      if (kk == 1) set_ena(which, 1'b0);
      cycle_check(which, kk, exp_q, q_is_addr, tag);
    end
  endtask

  task automatic set_cfg(input logic [23:0] a, input logic [23:0] i, input logic [23:0] b);
    a_cfg = a;
    i_cfg = i;
    b_cfg = b;
  endtask

  logic [23:0] round_exp;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ena_a = 1'b0;
    ena_b = 1'b0;
    set_cfg(24'd0, 24'd0, 24'd0);
    repeat (3) @(negedge clk);

    check("rst_a wren",   32'(wren_a), 32'd0);
    check("rst_a done",   32'(done_a), 32'd0);
    check("rst_a rdAddr", 32'(rd_a),   32'd0);
    check("rst_a wrAddr", 32'(wa_a),   32'd0);
    check("rst_a q",      32'(q_a),    32'd0);
    check("rst_b wren",   32'(wren_b), 32'd0);
    check("rst_b done",   32'(done_b), 32'd0);
    check("rst_b q",      32'(q_b),    32'd0);

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("idle wren", 32'(wren_a), 32'd0);
    check("idle done", 32'(done_a), 32'd0);

    // 128*100 >> 7 = 100, plus b = 5.
    set_cfg(24'd128, 24'd100, 24'd5);
    run_frame(0, 24'd105, 1'b0, "basic");

    // 64*201 = 12864, /128 = 100.5.
`ifdef CALCU_Q_ROUND_EN
    round_exp = 24'd101;
`else
    round_exp = 24'd100;
`endif
    set_cfg(24'd64, 24'd201, 24'd0);
    run_frame(0, round_exp, 1'b0, "round");

    set_cfg(24'd256, 24'd200, 24'd0);
    run_frame(0, 24'd255, 1'b0, "sat_prod");
    set_cfg(24'd0, 24'd255, 24'd300);
    run_frame(0, 24'd255, 1'b0, "sat_b");
    set_cfg(24'd0, 24'd0, 24'd0);
    run_frame(0, 24'd0, 1'b0, "zero");

    run_frame(1, 24'd0, 1'b1, "lat3");

    // Abort while the third write (wrAddr 2) is on the bus.
    set_cfg(24'd128, 24'd100, 24'd5);
    @(negedge clk);
    ena_a = 1'b1;
    for (int kk = 1; kk <= 5; kk++) begin
      @(negedge clk);
      if (kk == 1) ena_a = 1'b0;
      cycle_check(0, kk, 24'd105, 1'b0, "pre_rst");
    end
    rst_a = 1'b0;
    @(negedge clk);
    check("abort wren",   32'(wren_a), 32'd0);
    check("abort done",   32'(done_a), 32'd0);
    check("abort rdAddr", 32'(rd_a),   32'd0);
    rst_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("post_abort wren", 32'(wren_a), 32'd0);
      check("post_abort done", 32'(done_a), 32'd0);
    end
    run_frame(0, 24'd105, 1'b0, "fresh");

    // ena held high: a new frame every 12 cycles, ena ignored mid-frame.
    @(negedge clk);
    ena_a = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      cycle_check(0, (k - 1) % 12 + 1, 24'd105, 1'b0, "hold");
      if (k == 36) ena_a = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_end wren", 32'(wren_a), 32'd0);
      check("hold_end rdAddr", 32'(rd_a), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
